// File: rtl/result_bcd_display.sv
// Converts a 20-bit binary result to six BCD digits and 7-segment patterns.
// Optional `LEADING_ZERO_BLANK_EN blanks zero digits above the top nonzero digit.
module result_bcd_display #(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [19:0] value,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [23:0] bcd,
   output logic        overflow,
   output logic [6:0]  hex0,
   output logic [6:0]  hex1,
   output logic [6:0]  hex2,
   output logic [6:0]  hex3,
   output logic [6:0]  hex4,
   output logic [6:0]  hex5
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   // Segment tables are written active-low; POL flips them for active-high boards.
   localparam logic [6:0] POL  = SEG_ACTIVE_LOW ? 7'h00 : 7'h7F;
   localparam logic [6:0] DASH = 7'h3F ^ POL;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [6:0] BLANK = 7'h7F ^ POL;
`endif

   state_t      state;
   logic [47:0] sr;
   logic [47:0] nxt;
   logic [4:0]  cnt;
   logic [41:0] hex_r;

   function automatic logic [47:0] dabble(input logic [47:0] s);
      logic [47:0] t;
      t = s;
      for (int i = 0; i < 7; i++) begin
         if (t[20+4*i +: 4] >= 4'd5)
            t[20+4*i +: 4] = t[20+4*i +: 4] + 4'd3;
      end
      return {t[46:0], 1'b0};
   endfunction

   function automatic logic [6:0] seg(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'h40;
         4'd1:    p = 7'h79;
         4'd2:    p = 7'h24;
         4'd3:    p = 7'h30;
         4'd4:    p = 7'h19;
         4'd5:    p = 7'h12;
         4'd6:    p = 7'h02;
         4'd7:    p = 7'h78;
         4'd8:    p = 7'h00;
         4'd9:    p = 7'h10;
         default: p = 7'h7F;
      endcase
      return p ^ POL;
   endfunction

   function automatic logic [41:0] render(
      input logic [23:0] b,
      input logic        ovf
   );
      logic [41:0] h;
      logic [3:0]  d;
`ifdef LEADING_ZERO_BLANK_EN
      logic        lead;
      lead = 1'b1;
`endif
      h = '0;
      for (int i = 5; i >= 0; i--) begin
         d = b[4*i +: 4];
         h[7*i +: 7] = ovf ? DASH : seg(d);
`ifdef LEADING_ZERO_BLANK_EN
         if (!ovf && lead && i != 0 && d == 4'd0)
            h[7*i +: 7] = BLANK;
         else if (d != 4'd0)
            lead = 1'b0;
`endif
      end
      return h;
   endfunction

   assign nxt = dabble(sr);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         sr       <= '0;
         cnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         bcd      <= '0;
         overflow <= 1'b0;
         hex_r    <= render(24'h0, 1'b0);
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sr    <= {28'b0, value};
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sr  <= nxt;
               cnt <= cnt + 5'd1;
               // Last iteration: publish the freshly shifted result directly.
               if (cnt == 5'd19) begin
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  bcd      <= nxt[43:20];
                  overflow <= |nxt[47:44];
                  hex_r    <= render(nxt[43:20], |nxt[47:44]);
                  state    <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign hex0 = hex_r[6:0];
   assign hex1 = hex_r[13:7];
   assign hex2 = hex_r[20:14];
   assign hex3 = hex_r[27:21];
   assign hex4 = hex_r[34:28];
   assign hex5 = hex_r[41:35];

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench for result_bcd_display (active-low segments).
// Expected digits come from integer arithmetic, not from shifting.
module tb_result_bcd_display;

   typedef struct {
      logic [23:0] bcd;
      logic        ovf;
      logic [41:0] hex;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] value = '0;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [23:0] bcd;
   logic        overflow;
   logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;
   exp_t q[$];
   exp_t last;

   result_bcd_display dut (
      .clk(clk), .rst(rst), .value(value), .start(start),
      .busy(busy), .done(done), .bcd(bcd), .overflow(overflow),
      .hex0(hex0), .hex1(hex1), .hex2(hex2),
      .hex3(hex3), .hex4(hex4), .hex5(hex5)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [41:0] hexbus();
      return {hex5, hex4, hex3, hex2, hex1, hex0};
   endfunction

   task automatic check(input string tag, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [19:0] v);
      exp_t        e;
      int unsigned n, low, d;
      logic [6:0]  tbl [10];
      logic        lead;
      tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
      n = v;
      e.ovf = (n > 999999);
      low = n % 1000000;
      e.bcd = '0;
      e.hex = '0;
      e.acc = 0;
      lead = 1'b1;
      for (int i = 5; i >= 0; i--) begin
         d = (low / (10 ** i)) % 10;
         e.bcd[4*i +: 4] = d[3:0];
         if (e.ovf)
            e.hex[7*i +: 7] = 7'h3F;
         else
            e.hex[7*i +: 7] = tbl[d];
`ifdef LEADING_ZERO_BLANK_EN
         if (!e.ovf && lead && i != 0 && d == 0)
            e.hex[7*i +: 7] = 7'h7F;
`endif
         if (d != 0)
            lead = 1'b0;
      end
      return e;
   endfunction

   // Called at a falling edge; start is sampled by the next rising edge.
   task automatic go(input logic [19:0] v);
      exp_t e;
      value = v;
      start = 1'b1;
      e = model(v);
      e.acc = cyc;
      q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      value = ~v;
      check("busy_rise", busy, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         check("done_timeout", 0, 1);
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      exp_t r;
      r = model(20'd0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_bcd"}, bcd, 0);
      check({tag, "_ovf"}, overflow, 0);
      check({tag, "_hex"}, hexbus(), r.hex);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst && done) begin
         done_cnt++;
         check("busy_with_done", busy, 0);
         if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = q.pop_front();
            check("bcd", bcd, e.bcd);
            check("overflow", overflow, e.ovf);
            check("hex", hexbus(), e.hex);
            check("latency", cyc - e.acc, 21);
            last = e;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dc;
      repeat (2) @(negedge clk);
      check_reset_state("rst_held");
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("rst_released");

      go(20'd0);
      wait_idle();
      go(20'd225);
      wait_idle();

      // Outputs hold while idle even as value wanders.
      value = 20'h12345;
      repeat (5) @(negedge clk);
      check("hold_bcd", bcd, last.bcd);
      check("hold_hex", hexbus(), last.hex);
      check("idle_busy", busy, 0);

      go(20'd999999);
      wait_idle();
      go(20'hFFFFF);
      wait_idle();
      go(20'd1000000);
      wait_idle();
      go(20'd100);
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         go(20'($urandom_range(0, 20'hFFFFF)));
         wait_idle();
      end

      // A second start during SHIFT must be dropped.
      dc = done_cnt;
      go(20'd42);
      repeat (3) @(negedge clk);
      value = 20'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (25) @(negedge clk);
      check("single_done", done_cnt - dc, 1);

      // Reset mid-conversion aborts without a done pulse.
      dc = done_cnt;
      go(20'd123456);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1 check_reset_state("rst_abort");
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      go(20'd15);
      wait_idle();
      check("abort_done_cnt", done_cnt - dc, 1);
      check("after_abort_bcd", bcd, 24'h000015);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/result_bcd_display.md
RESULT_BCD_DISPLAY -- requirements
Module: result_bcd_display

Interface
REQ-001 Parameter: SEG_ACTIVE_LOW, default 1, 1 = segment lit when bit is 0 (board default), 0 = lit when 1.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: value  input  20  unsigned binary result from the ALU stage to convert.
REQ-005 Port: start  input  1  request; samples value when accepted.
REQ-006 Port: busy  output  1  high while a conversion is in progress.
REQ-007 Port: done  output  1  one-cycle pulse when new results are valid.
REQ-008 Port: bcd  output  24  six packed BCD digits, [3:0] = ones.
REQ-009 Port: overflow  output  1  high when the last converted value exceeds 999999.
REQ-010 Port: hex0..hex5  output  7 each  segment patterns {g,f,e,d,c,b,a}; hex0 = ones digit.

Function
REQ-011 The FSM SHALL have the states IDLE, SHIFT and DONE.
REQ-012 In IDLE, start=1 SHALL latch value into a 48-bit shift register {28'b0, value}, clear the iteration counter, and move to SHIFT; busy rises the next cycle.
REQ-013 SHIFT SHALL perform one double-dabble iteration per cycle: add 3 to each BCD nibble ≥5, then shift left 1; exactly 20 iterations.
REQ-014 After iteration 20, the FSM SHALL enter DONE, load bcd/overflow/hex registers, assert done for one cycle, and return to IDLE.
REQ-015 Latency: start sampled at edge N → done high during cycle N+21; busy high cycles N+1..N+20.
REQ-016 start during SHIFT or DONE SHALL be ignored; it is not queued.
REQ-017 overflow SHALL be 1 iff the 7th BCD digit (bits [27:24] of the 28-bit BCD) is nonzero; bcd carries the low six digits regardless.
REQ-018 On overflow, hex0..hex5 SHALL all show dash (segment g only).
REQ-019 Digit decode SHALL cover 0-9 only; with SEG_ACTIVE_LOW=1: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10, dash=0x3F, blank=0x7F; SEG_ACTIVE_LOW=0 inverts all.
REQ-020 bcd, overflow, hex SHALL hold their last value between done pulses; value changes while busy SHALL not affect the conversion in progress.

Reset
REQ-021 rst SHALL force, without clock: state IDLE, busy=0, done=0, bcd=0, overflow=0, hex outputs showing value 0 (per REQ-024 when enabled).
REQ-022 rst during SHIFT SHALL abort; no done pulse follows, and start SHALL be accepted on the first edge after rst deasserts.
REQ-023 busy and done SHALL never be high together.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN: when defined, zero digits above the most significant nonzero digit SHALL show blank; hex0 always shows a digit; reset shows hex0=0, hex1..hex5 blank; overflow dash display unaffected.
REQ-025 When LEADING_ZERO_BLANK_EN is undefined, all six digits SHALL always display, including leading zeros.

Verification (SEG_ACTIVE_LOW=1)
REQ-026 Reset, start with value=0 → done at N+21, bcd=0x000000, overflow=0, hex0..hex5=0x40 (hex1..hex5=0x7F with macro).
REQ-027 value=225 → bcd=0x000225, hex2=0x24, hex1=0x24, hex0=0x12, hex3..hex5=0x40 (0x7F with macro).
REQ-028 value=999999 → bcd=0x999999, overflow=0, all hex=0x10; value=0xFFFFF → overflow=1, bcd=0x048575, all hex=0x3F.
REQ-029 start with value=42, then start with value=7 at N+5 → single done at N+21, bcd=0x000042; no second done.
REQ-030 start at N, rst pulsed at N+10 → busy=0 immediately, no done, outputs at reset values; start with value=15 after release → bcd=0x000015 at +21.
